// File: rtl/mii_mac_pkg.sv
// Shared constants and types for the MII MAC transmit path.
package mii_mac_pkg;

    // Ethernet preamble filler byte and start-of-frame delimiter.
    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

    // Standard framing: 7 preamble bytes and a 12-byte inter-frame gap.
    localparam int DEFAULT_PREAMBLE_LEN = 7;
    localparam int DEFAULT_IFG_BYTES    = 12;

    // Frame-level phases of the preamble/SFD inserter.
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREAMBLE = 3'd1,
        S_SFD      = 3'd2,
        S_DATA     = 3'd3,
        S_IFG      = 3'd4
    } prepend_preamble_state_t;

endpackage

// File: rtl/prepend_preamble.sv
// Prepends PREAMBLE_LEN x 0x55 plus the 0xD5 SFD to each frame, forwards
// the frame bytes with one cycle of latency, then holds off upstream for
// IFG_BYTES ready cycles of idle after the last byte.
//
// Handshake: a byte moves on either side on a rising clock edge where that
// side's tvalid and tready are both high. Once maxis_tvalid is raised, the
// output byte and its flags hold until it is taken. The upstream byte that
// starts a frame is only observed, not consumed, until the SFD has gone out.
//
// When the gap ends on a cycle where the next frame is already waiting (or
// when IFG_BYTES is 0 and the next frame waits at the last-byte transfer),
// the first preamble byte is loaded on that same edge, so back-to-back frames
// are separated by exactly IFG_BYTES idle slots.
module prepend_preamble
    import mii_mac_pkg::*;
#(
    parameter int PREAMBLE_LEN = DEFAULT_PREAMBLE_LEN,
    parameter int IFG_BYTES    = DEFAULT_IFG_BYTES
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [7:0]              saxis_tdata,
    input  logic                    saxis_tvalid,
    output logic                    saxis_tready,
    input  logic                    saxis_tlast,
    input  logic                    saxis_tuser,
    output logic [7:0]              maxis_tdata,
    output logic                    maxis_tvalid,
    input  logic                    maxis_tready,
    output logic                    maxis_tlast,
    output logic                    maxis_tuser,
    output prepend_preamble_state_t fsm_state
);

    // Counter value at which the final preamble byte is being transferred.
    localparam logic [3:0] PRE_LAST = 4'(PREAMBLE_LEN - 1);
    localparam logic [7:0] IFG_INIT = 8'(IFG_BYTES);
    localparam bit         IFG_NONE = (IFG_BYTES == 0);

    prepend_preamble_state_t state_q, state_d;

    // Output register.
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       last_q, last_d;
    logic       user_q, user_d;

    // Preamble bytes already transferred, and remaining idle gap slots.
    logic [3:0] pre_cnt_q, pre_cnt_d;
    logic [7:0] ifg_cnt_q, ifg_cnt_d;

    logic out_xfer;
    logic held_last;
    logic ifg_done;
    logic accept;
    logic start;

    assign out_xfer  = valid_q && maxis_tready;
    assign held_last = valid_q && last_q;
    // The gap is over on the ready cycle that consumes its final slot.
    assign ifg_done  = maxis_tready && (ifg_cnt_q <= 8'd1);

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: advance on output transfers and gap completion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (saxis_tvalid) begin
                    state_d = S_PREAMBLE;
                end
            end
            S_PREAMBLE: begin
                if (out_xfer && (pre_cnt_q == PRE_LAST)) begin
                    state_d = S_SFD;
                end
            end
            S_SFD: begin
                if (out_xfer) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (out_xfer && last_q) begin
                    if (IFG_NONE) begin
                        state_d = saxis_tvalid ? S_PREAMBLE : S_IDLE;
                    end else begin
                        state_d = S_IFG;
                    end
                end
            end
            S_IFG: begin
                if (ifg_done) begin
                    state_d = saxis_tvalid ? S_PREAMBLE : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic: upstream ready plus next output-register and counter values.
    always_comb begin
        accept    = 1'b0;
        start     = 1'b0;
        data_d    = data_q;
        valid_d   = valid_q;
        last_d    = last_q;
        user_d    = user_q;
        pre_cnt_d = pre_cnt_q;
        ifg_cnt_d = ifg_cnt_q;
        case (state_q)
            S_IDLE: begin
                start = saxis_tvalid;
            end
            S_PREAMBLE: begin
                if (out_xfer) begin
                    pre_cnt_d = pre_cnt_q + 4'd1;
                    data_d    = (pre_cnt_q == PRE_LAST) ? SFD_BYTE : PREAMBLE_BYTE;
                end
            end
            S_SFD: begin
                // The register empties so the first frame byte can be fetched.
                if (out_xfer) begin
                    valid_d = 1'b0;
                end
            end
            S_DATA: begin
                // A held last byte blocks the next frame's first byte.
                accept = (!valid_q || maxis_tready) && !held_last;
                if (saxis_tvalid && accept) begin
                    data_d  = saxis_tdata;
                    last_d  = saxis_tlast;
                    user_d  = saxis_tuser;
                    valid_d = 1'b1;
                end else if (out_xfer) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    user_d  = 1'b0;
                    if (last_q) begin
                        ifg_cnt_d = IFG_INIT;
                        start     = IFG_NONE && saxis_tvalid;
                    end
                end
            end
            S_IFG: begin
                if (maxis_tready) begin
                    if (ifg_cnt_q != 8'd0) begin
                        ifg_cnt_d = ifg_cnt_q - 8'd1;
                    end
                    start = ifg_done && saxis_tvalid;
                end
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
        // Every frame opens with a clean preamble byte and a cleared counter.
        if (start) begin
            data_d    = PREAMBLE_BYTE;
            valid_d   = 1'b1;
            last_d    = 1'b0;
            user_d    = 1'b0;
            pre_cnt_d = 4'd0;
        end
    end

    // Output register and counters; reset abandons any frame in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            user_q    <= 1'b0;
            pre_cnt_q <= 4'd0;
            ifg_cnt_q <= 8'd0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            user_q    <= user_d;
            pre_cnt_q <= pre_cnt_d;
            ifg_cnt_q <= ifg_cnt_d;
        end
    end

    assign saxis_tready = accept;
    assign maxis_tdata  = data_q;
    assign maxis_tvalid = valid_q;
    assign maxis_tlast  = last_q;
    assign maxis_tuser  = user_q;
    assign fsm_state    = state_q;

endmodule

// File: tb/tb_prepend_preamble.sv
// Bench for prepend_preamble: lane 0 uses 7 preamble bytes and a 12-slot gap,
// lane 1 uses 1 preamble byte and no gap. Beats are packed {tuser, tlast, tdata}.
module tb_prepend_preamble;
    import mii_mac_pkg::*;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic [7:0] s_tdata [2];
    logic       s_tvalid [2];
    logic       s_tready [2];
    logic       s_tlast [2];
    logic       s_tuser [2];
    logic [7:0] m_tdata [2];
    logic       m_tvalid [2];
    logic       m_tready [2];
    logic       m_tlast [2];
    logic       m_tuser [2];
    prepend_preamble_state_t st0, st1;

    prepend_preamble #(.PREAMBLE_LEN(7), .IFG_BYTES(12)) dut0 (
        .clock(clock), .reset(reset),
        .saxis_tdata(s_tdata[0]), .saxis_tvalid(s_tvalid[0]), .saxis_tready(s_tready[0]),
        .saxis_tlast(s_tlast[0]), .saxis_tuser(s_tuser[0]),
        .maxis_tdata(m_tdata[0]), .maxis_tvalid(m_tvalid[0]), .maxis_tready(m_tready[0]),
        .maxis_tlast(m_tlast[0]), .maxis_tuser(m_tuser[0]),
        .fsm_state(st0)
    );

    prepend_preamble #(.PREAMBLE_LEN(1), .IFG_BYTES(0)) dut1 (
        .clock(clock), .reset(reset),
        .saxis_tdata(s_tdata[1]), .saxis_tvalid(s_tvalid[1]), .saxis_tready(s_tready[1]),
        .saxis_tlast(s_tlast[1]), .saxis_tuser(s_tuser[1]),
        .maxis_tdata(m_tdata[1]), .maxis_tvalid(m_tvalid[1]), .maxis_tready(m_tready[1]),
        .maxis_tlast(m_tlast[1]), .maxis_tuser(m_tuser[1]),
        .fsm_state(st1)
    );

    // ---------------- model state ----------------
    int checks = 0;
    int errors = 0;
    logic [9:0] src_q0[$], src_q1[$];
    logic [9:0] exp_q0[$], exp_q1[$];
    logic [9:0] obs_q0[$], obs_q1[$];
    logic       acc [2];
    logic [9:0] head_v;
    logic       have_v;
    bit         rnd_ready;
    bit         gap_mode;
    bit         prev_stall [2];
    bit         gap_on [2];
    bit         waiting [2];
    logic [10:0] prev_out [2];
    int         gap_cnt [2];
    int         last_gap [2];

    function automatic int plen(input int k);
        return (k == 0) ? 7 : 1;
    endfunction

    function automatic int ifg(input int k);
        return (k == 0) ? 12 : 0;
    endfunction

    function automatic int pending(input int k);
        return (k == 0) ? (exp_q0.size() + src_q0.size()) : (exp_q1.size() + src_q1.size());
    endfunction

    function automatic int obs_size(input int k);
        return (k == 0) ? obs_q0.size() : obs_q1.size();
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input int k, input logic [9:0] beat);
        if (k == 0) exp_q0.push_back(beat);
        else exp_q1.push_back(beat);
    endtask

    // Queue a frame: upstream bytes, and the full expected output sequence.
    task automatic send_frame(input int k, input int n, input logic [7:0] start, input logic user_last);
        logic [9:0] beat;
        for (int i = 0; i < plen(k); i++) push_exp(k, {2'b00, 8'h55});
        push_exp(k, {2'b00, 8'hD5});
        for (int i = 0; i < n; i++) begin
            beat[7:0] = start + 8'(i);
            beat[8]   = (i == n - 1);
            beat[9]   = user_last && (i == n - 1);
            push_exp(k, beat);
            if (k == 0) src_q0.push_back(beat);
            else src_q1.push_back(beat);
        end
    endtask

    // ---------------- driver ----------------
    always @(negedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (acc[k]) begin
                if (k == 0) void'(src_q0.pop_front());
                else void'(src_q1.pop_front());
            end
            acc[k] = 1'b0;
            m_tready[k] = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            have_v = 1'b0;
            head_v = 10'd0;
            if (k == 0 && src_q0.size() != 0) begin have_v = 1'b1; head_v = src_q0[0]; end
            if (k == 1 && src_q1.size() != 0) begin have_v = 1'b1; head_v = src_q1[0]; end
            if (have_v && !(gap_mode && $urandom_range(0, 3) == 0)) begin
                s_tvalid[k] = 1'b1;
                {s_tuser[k], s_tlast[k], s_tdata[k]} = head_v;
            end else begin
                s_tvalid[k] = 1'b0;
                s_tuser[k]  = 1'b0;
                s_tlast[k]  = 1'b0;
                s_tdata[k]  = 8'h00;
            end
        end
        #1;
        for (int k = 0; k < 2; k++) acc[k] = s_tvalid[k] && s_tready[k] && !reset;
    end

    // ---------------- compare ----------------
    task automatic compare_lane(input int k);
        logic [10:0] cur;
        logic [9:0]  beat;
        logic [9:0]  req;
        cur  = {m_tvalid[k], m_tuser[k], m_tlast[k], m_tdata[k]};
        beat = cur[9:0];
        if (prev_stall[k]) check($sformatf("hold%0d", k), 32'(cur), 32'(prev_out[k]));
        prev_stall[k] = m_tvalid[k] && !m_tready[k];
        prev_out[k]   = cur;
        if (m_tvalid[k]) begin
            if (gap_on[k]) begin
                gap_on[k]   = 1'b0;
                last_gap[k] = gap_cnt[k];
                if (waiting[k]) check($sformatf("ifg_exact%0d", k), 32'(gap_cnt[k]), 32'(ifg(k)));
                else check($sformatf("ifg_min%0d", k), 32'(gap_cnt[k] >= ifg(k)), 32'd1);
            end
            if (m_tready[k]) begin
                if ((k == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat%0d: got 0x%0h, required no transfer", k, beat);
                end else begin
                    if (k == 0) req = exp_q0.pop_front();
                    else req = exp_q1.pop_front();
                    check($sformatf("beat%0d", k), 32'(beat), 32'(req));
                end
                if (k == 0) obs_q0.push_back(beat);
                else obs_q1.push_back(beat);
                if (m_tlast[k]) begin
                    gap_on[k]  = 1'b1;
                    gap_cnt[k] = 0;
                    waiting[k] = (ifg(k) == 0) && s_tvalid[k];
                end
            end
        end else if (gap_on[k] && m_tready[k]) begin
            gap_cnt[k]++;
            if (gap_cnt[k] == ifg(k)) waiting[k] = s_tvalid[k];
        end
    endtask

    always @(negedge clock) begin
        #2;
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                prev_stall[k] = 1'b0;
                gap_on[k]     = 1'b0;
                waiting[k]    = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) compare_lane(k);
        end
    end

    // ---------------- wait helpers ----------------
    task automatic wait_drain(input int k, input int budget);
        int n;
        n = 0;
        while (n < budget && pending(k) != 0) begin
            @(negedge clock);
            #3;
            n++;
        end
        check($sformatf("drain%0d", k), 32'(pending(k)), 32'd0);
    endtask

    task automatic wait_obs(input int k, input int cnt, input int budget);
        int n;
        n = 0;
        while (n < budget && obs_size(k) < cnt) begin
            @(negedge clock);
            #3;
            n++;
        end
        check($sformatf("reach%0d_%0d", k, cnt), 32'(obs_size(k) >= cnt), 32'd1);
    endtask

    task automatic count_quiet(input int k, input int cycles, output int seen);
        seen = 0;
        repeat (cycles) begin
            @(negedge clock);
            #3;
            if (m_tvalid[k]) seen++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int quiet;
        reset = 1'b0;
        rnd_ready = 1'b0;
        gap_mode = 1'b0;
        for (int k = 0; k < 2; k++) begin
            acc[k] = 1'b0; s_tvalid[k] = 1'b0; s_tdata[k] = 8'h00;
            s_tlast[k] = 1'b0; s_tuser[k] = 1'b0; m_tready[k] = 1'b1;
            prev_stall[k] = 1'b0; gap_on[k] = 1'b0; waiting[k] = 1'b0;
            gap_cnt[k] = 0; last_gap[k] = -1; prev_out[k] = 11'd0;
        end
        #1 reset = 1'b1;
        #2;
        check("rst_tvalid0", 32'(m_tvalid[0]), 32'd0);
        check("rst_tdata0", 32'(m_tdata[0]), 32'd0);
        check("rst_tlast_tuser1", 32'({m_tlast[1], m_tuser[1]}), 32'd0);
        check("rst_state0", 32'(st0), 32'(S_IDLE));
        @(posedge clock);
        @(posedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        #3;
        check("idle_after_rst_tvalid", 32'(m_tvalid[0]), 32'd0);
        check("idle_after_rst_state1", 32'(st1), 32'(S_IDLE));

        // 64-byte frame 00..3F, always ready
        obs_q0.delete();
        send_frame(0, 64, 8'h00, 1'b0);
        wait_drain(0, 2000);
        count_quiet(0, 14, quiet);
        check("ifg_quiet", 32'(quiet), 32'd0);
        check("f64_len", 32'(obs_q0.size()), 32'd72);
        check("f64_pre0", 32'(obs_q0[0]), 32'h055);
        check("f64_pre6", 32'(obs_q0[6]), 32'h055);
        check("f64_sfd", 32'(obs_q0[7]), 32'h0D5);
        check("f64_first", 32'(obs_q0[8]), 32'h000);
        check("f64_last", 32'(obs_q0[71]), 32'h13F);

        // same frame, random downstream stalls
        rnd_ready = 1'b1;
        send_frame(0, 64, 8'h00, 1'b0);
        wait_drain(0, 4000);
        rnd_ready = 1'b0;
        count_quiet(0, 14, quiet);

        // 1-byte frame with tuser
        obs_q0.delete();
        send_frame(0, 1, 8'hAB, 1'b1);
        wait_drain(0, 2000);
        check("one_len", 32'(obs_q0.size()), 32'd9);
        check("one_pre_tuser", 32'(obs_q0[0]), 32'h055);
        check("one_byte", 32'(obs_q0[8]), 32'h3AB);
        count_quiet(0, 14, quiet);

        // second frame presented during the gap
        obs_q0.delete();
        send_frame(0, 8, 8'h40, 1'b0);
        wait_obs(0, 16, 2000);
        repeat (3) @(negedge clock);
        #3;
        send_frame(0, 5, 8'h60, 1'b0);
        wait_drain(0, 2000);
        check("b2b_gap", 32'(last_gap[0]), 32'd12);
        count_quiet(0, 14, quiet);

        // upstream bubbles plus random stalls
        gap_mode = 1'b1;
        rnd_ready = 1'b1;
        send_frame(0, 20, 8'h80, 1'b1);
        wait_drain(0, 4000);
        gap_mode = 1'b0;
        rnd_ready = 1'b0;
        count_quiet(0, 14, quiet);

        // reset in the middle of the payload
        obs_q0.delete();
        send_frame(0, 64, 8'h00, 1'b0);
        wait_obs(0, 28, 2000);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("midrst_tvalid", 32'(m_tvalid[0]), 32'd0);
        check("midrst_tdata", 32'(m_tdata[0]), 32'd0);
        check("midrst_flags", 32'({m_tlast[0], m_tuser[0]}), 32'd0);
        check("midrst_tready", 32'(s_tready[0]), 32'd0);
        acc[0] = 1'b0;
        src_q0.delete();
        exp_q0.delete();
        @(posedge clock);
        #2 reset = 1'b0;
        obs_q0.delete();
        send_frame(0, 4, 8'hC0, 1'b0);
        wait_drain(0, 2000);
        check("post_rst_len", 32'(obs_q0.size()), 32'd12);
        check("post_rst_pre", 32'(obs_q0[6]), 32'h055);
        check("post_rst_sfd", 32'(obs_q0[7]), 32'h0D5);
        check("post_rst_last", 32'(obs_q0[11]), 32'h1C3);

        // short preamble, no gap, back-to-back
        obs_q1.delete();
        send_frame(1, 2, 8'h11, 1'b0);
        send_frame(1, 1, 8'h33, 1'b0);
        wait_drain(1, 2000);
        check("nogap_len", 32'(obs_q1.size()), 32'd7);
        check("nogap_b1", 32'(obs_q1[1]), 32'h0D5);
        check("nogap_b3", 32'(obs_q1[3]), 32'h112);
        check("nogap_b4", 32'(obs_q1[4]), 32'h055);
        check("nogap_b6", 32'(obs_q1[6]), 32'h133);
        check("nogap_gap", 32'(last_gap[1]), 32'd0);

        repeat (4) @(negedge clock);
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
